// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BIN_W     = 15;
    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCRATCH_W = 20;
    localparam int unsigned ITER      = 15;
    localparam int unsigned CNT_W     = 4;
    localparam logic [15:0] BCD_MAX   = 16'h9999;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // 4-bit correction; no carry leaves the digit
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential 15-bit binary to 4-digit packed BCD converter (one bit per clock),
// saturating to 9999 with an overflow flag.
module bin_to_bcd
    import bcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0]       sr_q, sr_d;
    logic [SCRATCH_W-1:0]   scr_q, scr_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    logic [SCRATCH_W-1:0]   scr_adj;
    logic [SCRATCH_W-1:0]   scr_nx;
    logic [BIN_W-1:0]       sr_nx;
    logic                   spill;

    // One correction unit per scratch digit
    for (genvar g = 0; g < SCRATCH_W / 4; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr_q[4*g +: 4]),
            .dout (scr_adj[4*g +: 4])
        );
    end

    // Next-state, datapath and result selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        // Bit shifted out of the scratch top can only be set on a broken
        // correction; it is folded into the saturation test defensively.
        {spill, scr_nx, sr_nx} = {scr_adj, sr_q, 1'b0};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(ITER);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = scr_nx;
                sr_d  = sr_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (spill || (scr_nx[19:16] != 4'd0) || (scr_nx[15:0] > BCD_MAX)) begin
                        bcd_d = BCD_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        bcd_d = scr_nx[15:0];
                        ovf_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] bin = '0;
    logic        ready;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    bin_to_bcd dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .ready    (ready),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("bcd", {16'd0, bcd}, {16'd0, mon_e.bcd});
                chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
                chk("latency", cyc - mon_e.cyc, 32'd15);
                chk("ready_with_done", {31'd0, ready}, 32'd1);
            end
        end
    end

    // Wait for ready, issue one start, register the expected result
    task automatic convert(input logic [14:0] v, input logic [15:0] eb, input logic eo);
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{bcd: eb, ovf: eo, cyc: cyc});
        start = 1'b0;
        bin   = ~v;
        chk("ready_drop", {31'd0, ready}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    int unsigned n0;
    int unsigned c1;
    int unsigned c2;

    initial begin
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd", {16'd0, bcd}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        #19;
        @(negedge clk);
        rst_n = 1'b1;

        convert(15'd2000, 16'h2000, 1'b0);
        drain();
        convert(15'd0, 16'h0000, 1'b0);
        convert(15'd9999, 16'h9999, 1'b0);
        convert(15'd1234, 16'h1234, 1'b0);
        convert(15'd10000, 16'h9999, 1'b1);
        convert(15'd32767, 16'h9999, 1'b1);
        drain();

        // start mid-conversion must be ignored
        convert(15'd4321, 16'h4321, 1'b0);
        n0 = done_cnt;
        repeat (4) @(negedge clk);
        bin   = 15'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("single_done", done_cnt - n0, 32'd1);
        chk("idle_after_ignored", {31'd0, ready}, 32'd1);

        // back-to-back: second start accepted 16 edges after the first
        convert(15'd7, 16'h0007, 1'b0);
        c1 = sb[sb.size()-1].cyc;
        convert(15'd8, 16'h0008, 1'b0);
        c2 = sb[sb.size()-1].cyc;
        chk("b2b_accept", c2 - c1, 32'd16);
        drain();

        // reset at E8 of a conversion aborts it
        @(negedge clk);
        bin   = 15'd2000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n0 = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_bcd", {16'd0, bcd}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_no_done", done_cnt - n0, 32'd0);
        chk("abort_bcd_held", {16'd0, bcd}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
